avr_cpu_fetch_stage: RTL
========================

# avr_cpu_fetch_stage

Parametrised instruction-fetch stage for the AVR core. It owns the program counter, drives an external asynchronous-read program-memory port, and latches the fetched opcode for decode. It also contains a configurable-depth hardware return stack with overflow/underflow detection and arbitrates LPM data reads onto the same memory port. It sits between program memory and the decode/execute stage.

## Interface
- PC_WIDTH, 16, program counter width (words); must be >= PM_ADDR_WIDTH.
- PM_ADDR_WIDTH, 9, program-memory word address width.
- STACK_DEPTH, 8, return-stack entries, power of two, >= 2.
- CYCLE_WIDTH, 2, width of multi-cycle instruction counter.
- RESET_VECTOR, 0, first fetched word address.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_update  in  PC_WIDTH  signed relative offset added on normal/hold advance.
- hold  in  1  current instruction needs another cycle; opcode held.
- jump  in  1  absolute jump to jump_addr.
- jump_addr  in  PC_WIDTH  absolute target.
- push  in  1  push return address (pc+1) onto return stack.
- pop  in  1  pop return stack into pc.
- lpm_read  in  1  this cycle the memory port serves an LPM byte read.
- lpm_addr  in  PC_WIDTH  LPM byte address.
- lpm_data  out  8  selected LPM byte, combinational.
- pm_addr  out  PM_ADDR_WIDTH  program-memory word address, combinational.
- pm_data  in  16  program-memory word; valid in the same cycle as pm_addr.
- opcode  out  16  current instruction; reset 16'h0000 (NOP).
- pc  out  PC_WIDTH  address of word in opcode; reset RESET_VECTOR-1 (mod 2^PC_WIDTH).
- cycle  out  CYCLE_WIDTH  multi-cycle index of current instruction; reset 0.
- stack_level  out  log2(STACK_DEPTH)+1  valid entries; reset 0.
- stack_overflow  out  1  sticky; reset 0.
- stack_underflow  out  1  sticky; reset 0.

## Operation
- new_pc priority, evaluated only when lpm_read=0:
  - pop: top of stack.
  - else jump: jump_addr.
  - else hold: pc + pc_update.
  - else: pc + 1 + pc_update.
- All PC arithmetic is modulo 2^PC_WIDTH. pm_addr = new_pc[PM_ADDR_WIDTH-1:0].
- Register update when lpm_read=0:
  - pc <= new_pc.
  - if !hold: opcode <= pm_data.
- lpm_read=1:
  - pm_addr = lpm_addr[PM_ADDR_WIDTH:1]; lpm_data = lpm_addr[0] ? pm_data[15:8] : pm_data[7:0].
  - pc, opcode and stack are frozen; push/pop/jump ignored.
- cycle <= hold ? cycle+1 (saturating at all-ones) : 0. Updated regardless of lpm_read.
- push stores pc+1 and may coincide with jump or a relative advance (call semantics).
- Push when stack_level == STACK_DEPTH:
  - circular overwrite of the oldest entry; level stays STACK_DEPTH.
  - stack_overflow <= 1.
- Pop when empty:
  - new_pc falls through to the next priority rule.
  - level stays 0; stack_underflow <= 1.
- push and pop in the same cycle: pop wins, push dropped, stack_overflow <= 1 (error marker).
- Sticky flags clear only on rst.

## Timing
- Single-cycle fetch: control asserted in cycle n -> opcode/pc reflect the target at edge n+1.
- First edge after rst deasserts: opcode = pm[RESET_VECTOR], pc = RESET_VECTOR.
- rst mid-operation overrides everything: stack emptied, flags cleared, outputs to reset values on the same edge.
- pm_addr and lpm_data are the only combinational outputs. Memory must be asynchronous-read.

## Structure
- Shared package avr_cpu_pkg: OPCODE_W = 16, NOP = 16'h0000, stack level width function (clog2-based).
- Sub-module avr_cpu_retstack:
  - parametrised circular LIFO (DEPTH, WIDTH).
  - push/pop ports, top, level, overflow/underflow pulses.
  - the fetch stage owns the sticky flags.

## Test plan
- Reset, pm[i]=16'h1000+i, no controls -> after 3 edges opcode=16'h1002, pc=2, cycle=0.
- hold=1 for 2 cycles at pc=5 -> opcode unchanged, pc=5, cycle 1 then 2; release -> pc=6, cycle=0.
- push with pc_update=+10 at pc=4 -> pc=15, level=1; later pop -> pc=5, opcode=pm[5], level=0.
- STACK_DEPTH=4, five pushes -> overflow=1, level=4; four pops return the last four pushed addresses; fifth pop -> underflow=1, pc advances +1.
- lpm_read with lpm_addr=16'h0007, pm[3]=16'hABCD -> pm_addr=3, lpm_data=8'hAB, pc/opcode unchanged; a simultaneous jump is ignored.
- jump_addr=16'hFFFF at PC_WIDTH=16, next cycle normal -> pc wraps to 0, pm_addr=0.

Source files
------------

// File: rtl/avr_cpu_pkg.sv
// avr_cpu_pkg: shared opcode constants and return-stack sizing helper
package avr_cpu_pkg;
  localparam int OPCODE_W = 16;
  localparam logic [OPCODE_W-1:0] NOP = 16'h0000;
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/avr_cpu_fetch_stage_if.sv
// avr_cpu_fetch_stage_if: asynchronous-read program-memory port
interface avr_cpu_fetch_stage_if import avr_cpu_pkg::*; #(
  parameter int PM_ADDR_WIDTH = 9
);
  logic [PM_ADDR_WIDTH-1:0] pm_addr;
  logic [OPCODE_W-1:0] pm_data;
  modport master (output pm_addr, input pm_data);
  modport slave (input pm_addr, output pm_data);
endinterface

// File: rtl/avr_cpu_retstack.sv
// avr_cpu_retstack: circular LIFO; a full push overwrites the oldest entry
module avr_cpu_retstack import avr_cpu_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic [level_w(DEPTH)-1:0] o_level,
  output logic o_overflow,
  output logic o_underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_sp;
  logic [LW-1:0] r_level;
  logic w_empty, w_full, w_do_pop, w_do_push;
  assign w_empty = r_level == '0;
  assign w_full = r_level == LW'(DEPTH);
  assign w_do_pop = i_pop & ~w_empty;
  assign w_do_push = i_push & ~i_pop;
  assign o_top = r_mem[PW'(r_sp - 1'b1)];
  assign o_level = r_level;
  // a push colliding with a pop is dropped and flagged as an overflow-class error
  assign o_overflow = i_push & (i_pop | w_full);
  assign o_underflow = i_pop & w_empty;
  always_ff @(posedge clk)
    if (w_do_push) r_mem[r_sp] <= i_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= '0;
      r_level <= '0;
    end else if (w_do_pop) begin
      r_sp <= r_sp - 1'b1;
      r_level <= r_level - 1'b1;
    end else if (w_do_push) begin
      r_sp <= r_sp + 1'b1;
      r_level <= w_full ? r_level : r_level + 1'b1;
    end
  end
endmodule

// File: rtl/avr_cpu_fetch_stage.sv
// avr_cpu_fetch_stage: PC, opcode latch, return stack and LPM sharing of the program-memory port
module avr_cpu_fetch_stage import avr_cpu_pkg::*; #(
  parameter int PC_WIDTH = 16,
  parameter int PM_ADDR_WIDTH = 9,
  parameter int STACK_DEPTH = 8,
  parameter int CYCLE_WIDTH = 2,
  parameter int RESET_VECTOR = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic [PC_WIDTH-1:0] i_pc_update,
  input  logic i_hold,
  input  logic i_jump,
  input  logic [PC_WIDTH-1:0] i_jump_addr,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_lpm_read,
  input  logic [PC_WIDTH-1:0] i_lpm_addr,
  output logic [7:0] o_lpm_data,
  avr_cpu_fetch_stage_if.master pm,
  output logic [OPCODE_W-1:0] o_opcode,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [CYCLE_WIDTH-1:0] o_cycle,
  output logic [level_w(STACK_DEPTH)-1:0] o_stack_level,
  output logic o_stack_overflow,
  output logic o_stack_underflow
);
  logic [PC_WIDTH-1:0] r_pc, w_top, w_ret, w_new_pc;
  logic [OPCODE_W-1:0] r_opcode;
  logic [CYCLE_WIDTH-1:0] r_cycle;
  logic r_ovf, r_unf, w_ovf, w_unf, w_push, w_pop, w_pop_ok;
  assign w_push = i_push & ~i_lpm_read;
  assign w_pop = i_pop & ~i_lpm_read;
  assign w_pop_ok = w_pop & (o_stack_level != '0);
  assign w_ret = r_pc + 1'b1;
  always_comb
    w_new_pc = w_pop_ok ? w_top : i_jump ? i_jump_addr : i_hold ? r_pc + i_pc_update : w_ret + i_pc_update;
  // LPM byte address selects a word; bit 0 picks the byte lane
  assign pm.pm_addr = i_lpm_read ? PM_ADDR_WIDTH'(i_lpm_addr >> 1) : PM_ADDR_WIDTH'(w_new_pc);
  assign o_lpm_data = i_lpm_addr[0] ? pm.pm_data[15:8] : pm.pm_data[7:0];
  avr_cpu_retstack #(.DEPTH(STACK_DEPTH), .WIDTH(PC_WIDTH)) u_stack (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_pop), .i_data(w_ret),
    .o_top(w_top), .o_level(o_stack_level), .o_overflow(w_ovf), .o_underflow(w_unf)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= PC_WIDTH'(RESET_VECTOR - 1);
      r_opcode <= NOP;
      r_cycle <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_cycle <= !i_hold ? '0 : &r_cycle ? r_cycle : r_cycle + 1'b1;
      r_ovf <= r_ovf | w_ovf;
      r_unf <= r_unf | w_unf;
      if (!i_lpm_read) begin
        r_pc <= w_new_pc;
        if (!i_hold) r_opcode <= pm.pm_data;
      end
    end
  end
  assign o_pc = r_pc;
  assign o_opcode = r_opcode;
  assign o_cycle = r_cycle;
  assign o_stack_overflow = r_ovf;
  assign o_stack_underflow = r_unf;
endmodule
